// File: rtl/h264_pkg.sv
// Shared macroblock geometry, bank states and the 4x4-block to raster
// word address mapping used by the reconstruction macroblock store.
package h264_pkg;

   localparam int MB_LUMA_WORDS   = 64;
   localparam int MB_CHROMA_WORDS = 32;
   localparam int MB_WORDS        = 96;
   localparam int CHROMA_BASE     = 64;

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

   // Luma raster row = {n[5],n[3],n[1:0]}, 4-pixel word column = {n[4],n[2]}.
   function automatic logic [6:0] luma_raster_addr(input logic [5:0] n);
      return {1'b0, n[5], n[3], n[1:0], n[4], n[2]};
   endfunction

   function automatic logic [6:0] chroma_raster_addr(input logic [4:0] m);
      return 7'(CHROMA_BASE) + {2'b00, m[4], m[3], m[1:0], m[2]};
   endfunction

endpackage

// File: rtl/h264recon_mbstore_ram.sv
// Two-bank macroblock store: one write port, one registered read port.
// Contents are never cleared; the bank bookkeeping decides what is valid.
module h264recon_mbstore_ram
   import h264_pkg::*;
(
   input  logic        clk,
   input  logic        we,
   input  logic [7:0]  waddr,
   input  logic [31:0] wdata,
   input  logic        re,
   input  logic [7:0]  raddr,
   output logic [31:0] rdata
);

   logic [31:0] mem [0:2*MB_WORDS-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/h264recon_mbstore.sv
// Reorders reconstructed 4x4-block words into raster order in a ping-pong
// store and drains each completed macroblock over a valid/ready port.
module h264recon_mbstore
   import h264_pkg::*;
(
   input  logic        CLK2,
   input  logic        NEWSLICE,
   input  logic        STROBEI,
   input  logic        CSTROBEI,
   input  logic [31:0] DATAI,
   input  logic        WREADYI,
   output logic        WVALIDO,
   output logic [6:0]  WADDRO,
   output logic [31:0] WDATAO,
   output logic        WCHROMAO,
   output logic        MBDONEO,
   output logic        OVERFLOWO
);

   bank_state_t bank_state [2];
   logic        fill_bank, drain_bank, rd_bank;
   logic [6:0]  luma_cnt;
   logic [5:0]  chroma_cnt;
   logic [6:0]  rd_addr, rd_addr_q;
   logic        rd_valid;
   logic [31:0] ram_rdata;
   logic        skid_valid;
   logic [6:0]  skid_addr;
   logic [31:0] skid_data;

   logic        fill_stall, luma_take, chroma_take, wr_en;
   logic        luma_full_nxt, chroma_full_nxt, mb_complete;
   logic        pop, release_bank, other_free, rd_ok, rd_issue;
   logic [6:0]  wr_word;
   logic [7:0]  wr_addr, rd_ram_addr;
   logic [1:0]  occupancy;

   always_comb begin
      fill_stall      = (bank_state[fill_bank] == FULL) || (bank_state[fill_bank] == DRAINING);
      luma_take       = STROBEI && !fill_stall && (luma_cnt != 7'(MB_LUMA_WORDS));
      chroma_take     = CSTROBEI && !STROBEI && !fill_stall && (chroma_cnt != 6'(MB_CHROMA_WORDS));
      wr_en           = luma_take || chroma_take;
      wr_word         = luma_take ? luma_raster_addr(luma_cnt[5:0]) : chroma_raster_addr(chroma_cnt[4:0]);
      wr_addr         = fill_bank ? 8'(MB_WORDS) + {1'b0, wr_word} : {1'b0, wr_word};
      luma_full_nxt   = (luma_cnt == 7'(MB_LUMA_WORDS)) || (luma_take && luma_cnt == 7'(MB_LUMA_WORDS - 1));
      chroma_full_nxt = (chroma_cnt == 6'(MB_CHROMA_WORDS)) || (chroma_take && chroma_cnt == 6'(MB_CHROMA_WORDS - 1));
      mb_complete     = wr_en && luma_full_nxt && chroma_full_nxt;
      pop             = WVALIDO && WREADYI;
      release_bank    = pop && (WADDRO == 7'(MB_WORDS - 1));
      other_free      = (bank_state[!fill_bank] == EMPTY) || (release_bank && (drain_bank != fill_bank));
      // Reads run ahead of the output port; this credit keeps at most two words
      // buffered or in flight so the skid register can never overflow.
      occupancy       = {1'b0, WVALIDO} + {1'b0, skid_valid} + {1'b0, rd_valid} - {1'b0, pop};
      rd_ok           = (bank_state[rd_bank] == FULL) ||
                        ((bank_state[rd_bank] == DRAINING) && (rd_addr != 7'd0));
      rd_issue        = rd_ok && (occupancy < 2'd2);
      rd_ram_addr     = rd_bank ? 8'(MB_WORDS) + {1'b0, rd_addr} : {1'b0, rd_addr};
   end

   always_ff @(posedge CLK2) begin
      if (NEWSLICE) begin
         bank_state[0] <= EMPTY;
         bank_state[1] <= EMPTY;
         fill_bank     <= 1'b0;
         drain_bank    <= 1'b0;
         rd_bank       <= 1'b0;
         luma_cnt      <= '0;
         chroma_cnt    <= '0;
         rd_addr       <= '0;
         rd_addr_q     <= '0;
         rd_valid      <= 1'b0;
         OVERFLOWO     <= 1'b0;
      end else begin
         if ((STROBEI && (fill_stall || luma_cnt == 7'(MB_LUMA_WORDS))) ||
             (CSTROBEI && !STROBEI && (fill_stall || chroma_cnt == 6'(MB_CHROMA_WORDS))))
            OVERFLOWO <= 1'b1;

         if (mb_complete) begin
            luma_cnt   <= '0;
            chroma_cnt <= '0;
         end else begin
            if (luma_take)
               luma_cnt <= luma_cnt + 7'd1;
            if (chroma_take)
               chroma_cnt <= chroma_cnt + 6'd1;
         end

         rd_valid  <= rd_issue;
         rd_addr_q <= rd_addr;
         if (rd_issue) begin
            if (bank_state[rd_bank] == FULL)
               bank_state[rd_bank] <= DRAINING;
            if (rd_addr == 7'(MB_WORDS - 1)) begin
               rd_addr <= '0;
               rd_bank <= !rd_bank;
            end else begin
               rd_addr <= rd_addr + 7'd1;
            end
         end

         if (wr_en && bank_state[fill_bank] == EMPTY)
            bank_state[fill_bank] <= FILLING;
         if (mb_complete)
            bank_state[fill_bank] <= FULL;
         if (release_bank) begin
            bank_state[drain_bank] <= EMPTY;
            drain_bank             <= !drain_bank;
         end

         // A stalled fill side follows the bank being released by the drain.
         if (mb_complete ? other_free : (fill_stall && release_bank && drain_bank != fill_bank))
            fill_bank <= !fill_bank;
      end
   end

   always_ff @(posedge CLK2) begin
      if (NEWSLICE) begin
         WVALIDO    <= 1'b0;
         WADDRO     <= '0;
         WDATAO     <= '0;
         MBDONEO    <= 1'b0;
         skid_valid <= 1'b0;
         skid_addr  <= '0;
         skid_data  <= '0;
      end else begin
         MBDONEO <= release_bank;
         if (pop) begin
            if (skid_valid) begin
               WADDRO     <= skid_addr;
               WDATAO     <= skid_data;
               skid_valid <= rd_valid;
               skid_addr  <= rd_addr_q;
               skid_data  <= ram_rdata;
            end else begin
               WVALIDO <= rd_valid;
               if (rd_valid) begin
                  WADDRO <= rd_addr_q;
                  WDATAO <= ram_rdata;
               end
            end
         end else if (!WVALIDO) begin
            WVALIDO <= rd_valid;
            if (rd_valid) begin
               WADDRO <= rd_addr_q;
               WDATAO <= ram_rdata;
            end
         end else if (rd_valid) begin
            skid_valid <= 1'b1;
            skid_addr  <= rd_addr_q;
            skid_data  <= ram_rdata;
         end
      end
   end

   assign WCHROMAO = (WADDRO >= 7'(CHROMA_BASE));

   h264recon_mbstore_ram u_ram (
      .clk   (CLK2),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (DATAI),
      .re    (rd_issue),
      .raddr (rd_ram_addr),
      .rdata (ram_rdata)
   );

   strobe_exclusive: assert property (@(posedge CLK2) disable iff (NEWSLICE) !(STROBEI && CSTROBEI));

endmodule

// File: doc/h264recon_mbstore.md
Name: h264recon_mbstore

Overview:
- Sink for the reconstruction output stream (luma strobe, chroma strobe, 32-bit word of 4 pixels).
- Reassembles each macroblock from 4x4-block order into raster order.
- Double-buffers macroblocks in a ping-pong store.
- Drains each completed macroblock to the frame-store writer over a valid/ready interface, one 4-pixel word per handshake.

Parameters:
- None. Geometry constants live in the shared package.

Ports:
- CLK2  in  1  x2 clock; sole clock.
- NEWSLICE  in  1  reset: synchronous, active-high.
- STROBEI  in  1  luma word valid.
- CSTROBEI  in  1  chroma word valid.
- DATAI  in  32  4 pixels; pixel0 (leftmost) in [7:0].
- WREADYI  in  1  writer accepts word.
- WVALIDO  out  1  word valid.
- WADDRO  out  7  raster word address within MB (0-95).
- WDATAO  out  32  4 pixels, same packing as DATAI.
- WCHROMAO  out  1  set when WADDRO >= 64.
- MBDONEO  out  1  one-cycle pulse after the last word (address 95) of an MB is accepted.
- OVERFLOWO  out  1  sticky; a strobe arrived while no bank was free.

Behaviour:
- Reset, one cycle after NEWSLICE high: all outputs 0, fill/drain counters 0, both banks empty, fill bank = drain bank = 0. RAM contents are not cleared. NEWSLICE mid-drain or mid-fill aborts immediately; no MBDONEO is issued.
- Storage is 2 banks x 96 words x 32 bits, with a synchronous-read RAM.
- Fill, luma: counter n = 0..63 advances on STROBEI.
  - n[5:2] = 4x4 block index in H.264 order (quadrant n[5:4], sub-block n[3:2]).
  - n[1:0] = row within the block.
  - Write address = {n[5],n[3],n[1:0],n[4],n[2]}.
- Fill, chroma: counter m = 0..31 advances on CSTROBEI.
  - m[4] = Cb(0)/Cr(1); m[3:2] = block (raster 2x2); m[1:0] = row.
  - Write address = 64 + {m[4],m[3],m[1:0],m[2]}.
- Luma and chroma may interleave in any order.
- STROBEI and CSTROBEI high together is illegal: assert error; luma wins and the chroma word is dropped.
- Counters saturate at done (luma 64, chroma 32). Further strobes to a finished component before the MB completes are dropped and set OVERFLOWO.
- MB complete, when both components are done:
  - Bank is marked full; both counters clear the same cycle.
  - Fill bank toggles if the other bank is empty; otherwise the fill side stalls.
  - While stalled, all strobes are dropped and OVERFLOWO is set.
  - Fill resumes the cycle after the other bank is released.
- Drain, when the drain bank is full:
  - Emits raster addresses 0..95 in order.
  - First WVALIDO rises no earlier than 2 cycles after the bank is marked full.
  - With WREADYI held high, one word per cycle, no bubbles.
  - WVALIDO/WADDRO/WDATAO/WCHROMAO are held stable while WVALIDO && !WREADYI. WVALIDO never drops without a handshake.
- On handshake at address 95:
  - Bank is released (empty) and the drain bank toggles.
  - MBDONEO pulses the next cycle.
  - If the other bank is already full, its first WVALIDO follows within 2 cycles.
- Simultaneous events:
  - Release of bank X and fill completion of bank Y in the same cycle: both take effect, and the fill side moves to X in the next cycle.
  - A fill stall and a release in the same cycle: the strobe that cycle is dropped.
- Data path is pass-through: no arithmetic on pixel values.

Decomposition:
- Package h264_pkg holds:
  - MB_LUMA_WORDS = 64, MB_CHROMA_WORDS = 32, MB_WORDS = 96, CHROMA_BASE = 64.
  - Functions luma_raster_addr(n[5:0]) and chroma_raster_addr(m[4:0]) returning 7 bits.
  - Enum bank_state_t {EMPTY, FILLING, FULL, DRAINING}.
- One sub-module, h264recon_mbstore_ram: 192x32 simple dual-port RAM, 1 write port, 1 registered read port.
- Drain uses a 2-entry skid/output register to meet the stability and no-bubble rules.

Test Plan:
- Luma words DATAI = n (0..63) then chroma words 100+m, WREADYI = 1 -> WADDRO 0..95 contiguous.
  - WADDRO 0 carries n=0; WADDRO 1 carries n=4; WADDRO 4 carries n=1; WADDRO 63 carries n=63.
  - WADDRO 64 carries 100; WADDRO 80 carries 116.
  - WCHROMAO high from address 64; one MBDONEO.
- Backpressure: WREADYI toggles 1,0,0,1 repeating -> no word lost or duplicated; outputs stable while stalled; order identical to the first test.
- Two MBs back-to-back with WREADYI = 0 throughout -> both banks full, no OVERFLOWO. A third MB's first strobe sets OVERFLOWO and is dropped. Releasing WREADYI drains MB1 then MB2 intact.
- Chroma-first interleave (all 32 chroma words, then luma) -> the same raster output as in the first test.
- NEWSLICE at drain address 40 -> WVALIDO 0 next cycle, no MBDONEO, OVERFLOWO cleared. A new MB then drains from address 0 with the new data.
- Release of bank 0 (address 95 handshake) in the same cycle as the 96th word of bank 1 -> bank 1 drains next with first valid within 2 cycles; the next MB fills bank 0.
